// File: rtl/dff_bank_write_arbiter_if.sv
// dff_bank_write_arbiter_if: requester-side bus of the shared-register write arbiter
interface dff_bank_write_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic               clr;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic [1:0]         owner;
    logic [CNT_W-1:0]   wr_count;

    modport master (
        output req, wdata, clr,
        input  gnt, ack, q, q_valid, owner, wr_count
    );

    modport slave (
        input  req, wdata, clr,
        output gnt, ack, q, q_valid, owner, wr_count
    );
endinterface

// File: rtl/dff_bank_write_arbiter.sv
// dff_bank_write_arbiter: round-robin write sequencer for one shared WIDTH-bit register
module dff_bank_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic                     clk,
    input logic                     reset,
    dff_bank_write_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_win;
    logic [3:0]       r_gnt;
    logic [3:0]       r_ack;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [1:0]       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       w_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_win;

    // rotate so bit 0 is the requester at the pointer, then take the first set bit
    always_comb begin
        w_dbl = {bus.req, bus.req};
        w_rot = 4'(w_dbl >> r_ptr);
        w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_win = r_ptr + w_off;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_owner   <= '0;
            r_cnt     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clr) begin
                        r_q       <= '0;
                        r_q_valid <= 1'b0;
                        r_owner   <= '0;
                    end else if (|bus.req) begin
                        r_gnt   <= 4'b0001 << w_win;
                        r_win   <= w_win;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt <= '0;
                    if (bus.req[r_win]) begin
                        r_q       <= bus.wdata[r_win*WIDTH +: WIDTH];
                        r_q_valid <= 1'b1;
                        r_owner   <= r_win;
                        r_cnt     <= r_cnt + 1'b1;
                        r_ack     <= 4'b0001 << r_win;
                        r_ptr     <= r_win + 2'd1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.q        = r_q;
    assign bus.q_valid  = r_q_valid;
    assign bus.owner    = r_owner;
    assign bus.wr_count = r_cnt;
endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// tb_dff_bank_write_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_dff_bank_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dff_bank_write_arbiter_if #(.WIDTH(8), .CNT_W(2)) bus();
    dff_bank_write_arbiter #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] q;
        logic [1:0] owner;
        logic [1:0] cnt;
    } exp_t;

    exp_t       ack_q[$];
    logic [3:0] gnt_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_ptr = 0;
    logic [7:0] m_q = '0;
    logic       m_valid = 1'b0;
    logic [1:0] m_owner = '0;
    int         m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (bus.gnt != 4'b0) begin
                if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(bus.gnt), 32'h0);
                else chk("gnt", 32'(bus.gnt), 32'(gnt_q.pop_front()));
            end
            if (bus.ack != 4'b0) begin
                if (ack_q.size() == 0) chk("unexpected_ack", 32'(bus.ack), 32'h0);
                else begin
                    e = ack_q.pop_front();
                    chk("ack", 32'(bus.ack), 32'(e.ack));
                    chk("ack_q", 32'(bus.q), 32'(e.q));
                    chk("ack_owner", 32'(bus.owner), 32'(e.owner));
                    chk("ack_wr_count", 32'(bus.wr_count), 32'(e.cnt));
                    chk("ack_q_valid", 32'(bus.q_valid), 32'h1);
                end
            end
        end
    end

    function automatic int winner(input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_q"}, 32'(bus.q), 32'(m_q));
        chk({tag, "_q_valid"}, 32'(bus.q_valid), 32'(m_valid));
        chk({tag, "_owner"}, 32'(bus.owner), 32'(m_owner));
        chk({tag, "_wr_count"}, 32'(bus.wr_count), 32'(m_cnt));
        chk({tag, "_gnt_pending"}, 32'(gnt_q.size()), 32'h0);
        chk({tag, "_ack_pending"}, 32'(ack_q.size()), 32'h0);
    endtask

    // called one time unit after a rising edge with the arbiter idle
    task automatic txn(input logic [3:0] m, input logic c, input logic ab, input logic [31:0] d);
        int   w;
        exp_t e;
        bus.req   = m;
        bus.wdata = d;
        bus.clr   = c;
        if (c) begin
            m_q = '0;
            m_valid = 1'b0;
            m_owner = '0;
            @(posedge clk); #1;
        end else if (m == 4'b0) begin
            @(posedge clk); #1;
        end else begin
            w = winner(m);
            gnt_q.push_back(4'b0001 << w);
            if (!ab) begin
                m_q = d[w*8 +: 8];
                m_valid = 1'b1;
                m_owner = 2'(w);
                m_cnt = (m_cnt + 1) % 4;
                m_ptr = (w + 1) % 4;
                e.ack = 4'b0001 << w;
                e.q = m_q;
                e.owner = m_owner;
                e.cnt = 2'(m_cnt);
                ack_q.push_back(e);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (i != w) begin
                    bus.req[i] = 1'($urandom);
                    bus.wdata[i*8 +: 8] = 8'($urandom);
                end
            end
            bus.clr = 1'($urandom);
            if (ab) bus.req[w] = 1'b0;
            @(posedge clk); #1;
            if (!ab) begin
                @(posedge clk); #1;
            end
        end
        bus.clr = 1'b0;
        check_state(c ? "clr" : ab ? "abort" : "write");
    endtask

    initial begin
        bus.req = '0;
        bus.wdata = '0;
        bus.clr = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_q_valid", 32'(bus.q_valid), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_wr_count", 32'(bus.wr_count), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        txn(4'b0010, 1'b0, 1'b0, 32'h0000_A500);
        for (int i = 0; i < 5; i++) txn(4'b1111, 1'b0, 1'b0, 32'h4030_2010);
        txn(4'b0100, 1'b0, 1'b1, 32'h00EE_0000);
        txn(4'b1100, 1'b0, 1'b0, 32'h5566_0000);
        txn(4'b0001, 1'b1, 1'b0, 32'h0000_0077);
        txn(4'b0001, 1'b0, 1'b0, 32'h0000_0077);

        bus.req = 4'b1000;
        bus.wdata = 32'hCC00_0000;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_ack", 32'(bus.ack), 32'h0);
        chk("midrst_q", 32'(bus.q), 32'h0);
        chk("midrst_wr_count", 32'(bus.wr_count), 32'h0);
        bus.req = '0;
        m_ptr = 0; m_q = '0; m_valid = 1'b0; m_owner = '0; m_cnt = 0;
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_state("midrst");

        for (int i = 0; i < 250; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            txn(4'($urandom_range(1, 15)), r == 0, r == 2 || r == 3, $urandom);
            if (r == 1) txn(4'b0, 1'b0, 1'b0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
